svm_det_collect: RTL and testbench
==================================

SVM_DET_COLLECT -- requirements
Module: svm_det_collect

Interface
REQ-001 Parameter FEA_W, default 12, signed SVM score width (two's complement, FEA_F fractional bits).
REQ-002 Parameter SW_W, default 11, slide-window index width.
REQ-003 Parameter N_SW, default 1200, slide windows per frame.
REQ-004 Parameter DEPTH, default 16, detection FIFO depth, power of two.
REQ-005 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-low.
REQ-007 Port thr  input  FEA_W  signed detection threshold.
REQ-008 Port thr_load  input  1  captures thr into the internal threshold register.
REQ-009 Port i_valid  input  1  SVM score valid (one per window, no backpressure).
REQ-010 Port i_score  input  FEA_W  signed SVM result.
REQ-011 Port i_sw_id  input  SW_W  window index of i_score.
REQ-012 Port o_valid  output  1  detection FIFO head valid.
REQ-013 Port o_ready  input  1  consumer accepts head when o_valid and o_ready are both high.
REQ-014 Port o_sw_id  output  SW_W  window index of head entry.
REQ-015 Port o_score  output  FEA_W  score of head entry.
REQ-016 Port frame_done  output  1  one-cycle pulse carrying the frame summary.
REQ-017 Port det_count  output  SW_W  detections accepted this frame, saturating at all-ones.
REQ-018 Port best_sw_id  output  SW_W  window with highest score this frame.
REQ-019 Port best_score  output  FEA_W  highest score this frame.
REQ-020 Port overflow  output  1  at least one detection was dropped this frame (FIFO full).

Function
REQ-021 A window qualifies when i_valid is high and signed i_score > threshold register (strict).
- Equality does not qualify.
REQ-022 A qualifying window is pushed as {i_sw_id, i_score} on the same edge.
- o_valid rises one cycle after the push into an empty FIFO.
REQ-023 FIFO ordering is first-in first-out. o_sw_id and o_score hold stable while o_valid is high and o_ready is low.
REQ-024 On push while full:
- Without a same-cycle pop, the entry is dropped and overflow_r is set.
- With a same-cycle pop, both operations succeed and occupancy is unchanged.
REQ-025 Pop while empty has no effect. Pointers wrap modulo DEPTH.
REQ-026 State machine with two states:
- SCAN: the reset state; tracks the frame.
- REPORT: entered on the edge that accepts i_valid with i_sw_id == N_SW-1. Lasts exactly one cycle, asserts frame_done, then returns to SCAN.
REQ-027 In SCAN, for each qualifying window:
- det_cnt increments, saturating.
- If score > best_score_r (strict), or no detection yet this frame, best is updated to this window. Ties keep the earlier window.
REQ-028 The last window (N_SW-1) is included in the summary, including its push and best update.
- frame_done asserts the cycle after that window.
- det_count, best_sw_id, best_score and overflow are valid while frame_done is high.
- Those outputs hold until the next frame_done.
REQ-029 If no detection occurred in a frame, frame_done reports det_count=0, best_sw_id=0 and best_score=most-negative value.
REQ-030 On leaving REPORT, per-frame accumulators clear: det_cnt, best and overflow_r.
- An i_valid arriving in the REPORT cycle belongs to the next frame and is counted after the clear.
REQ-031 thr_load takes effect for windows arriving on the following cycle and later. It is permitted mid-frame.
REQ-032 FIFO contents are not flushed at frame boundaries.

Reset
REQ-033 Reset clears the following: FIFO pointers and occupancy, o_valid=0, frame_done=0, state=SCAN, det_cnt=0, det_count=0, best_sw_id=0, best_score=most-negative, overflow=0, threshold register=0.
- o_sw_id and o_score are 0 after reset.
REQ-034 Reset asserted mid-frame discards all FIFO entries and the partial frame. After release, collection restarts with the next i_valid.

Structure
REQ-035 A shared package holds:
- the detection entry record type {sw_id, score};
- the SCAN/REPORT state encoding;
- the most-negative score constant.
REQ-036 The FIFO is one sub-module, det_fifo, with push/pop, full/empty and registered head.
- The frame tracker and FSM stay in svm_det_collect.

Verification
REQ-037 thr=0, full frame with scores +5 at windows 10, 20 and 30, and -3 elsewhere, o_ready=1.
- Required: three pops in order 10, 20, 30.
- Required: frame_done one cycle after window 1199, with det_count=3, best_sw_id=10 (tie rule, all +5).
REQ-038 thr=0, o_ready=0, 20 qualifying windows.
- Required: the first 16 are stored, overflow=1 at frame_done, det_count=20.
- Required: raising o_ready drains exactly 16 entries in order.
REQ-039 FIFO full and o_ready=1 with a qualifying push in the same cycle.
- Required: occupancy stays 16 and no overflow.
REQ-040 thr=4: score 4 does not qualify, score 5 does.
- Required: a frame with only score-4 windows gives det_count=0 and best_score=most-negative.
REQ-041 Assert rst mid-frame with 3 FIFO entries pending.
- Required: o_valid=0 immediately.
- Required: the next full frame reports only its own detections.
REQ-042 i_valid with i_sw_id=0 in the REPORT cycle, qualifying.
- Required: it is counted in the next frame's det_count=1.

Source files
------------

// File: rtl/svm_det_collect_pkg.sv
// Shared types for the SVM detection collector: FIFO entry record, frame FSM
// encoding and the most-negative score used when a frame has no detection.
package svm_det_collect_pkg;

  localparam int DET_SW_W  = 11;
  localparam int DET_FEA_W = 12;

  typedef struct packed {
    logic        [DET_SW_W-1:0]  sw_id;
    logic signed [DET_FEA_W-1:0] score;
  } det_entry_t;

  typedef enum logic {
    ST_SCAN   = 1'b0,
    ST_REPORT = 1'b1
  } det_state_t;

  localparam logic signed [DET_FEA_W-1:0] SCORE_MIN = {1'b1, {(DET_FEA_W-1){1'b0}}};

endpackage

// File: rtl/svm_det_collect_fifo.sv
// Detection FIFO with a registered head: o_valid/o_head update on the same edge
// as the push or pop that changes them, so the head is glitch-free for the consumer.
module det_fifo
  import svm_det_collect_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  det_entry_t i_data,
  input  logic       i_pop,
  output logic       o_valid,
  output det_entry_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  det_entry_t     r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [AW:0]    r_cnt;
  logic           r_valid;
  det_entry_t     r_head;

  logic           w_pop;
  logic           w_wr;
  logic [AW-1:0]  w_rd_nx;
  logic [AW:0]    w_cnt_nx;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !o_empty;
  // A push into a full FIFO only lands when a pop frees a slot on the same edge.
  assign w_wr    = i_push && (!o_full || w_pop);
  assign w_rd_nx = r_rd + AW'(w_pop);
  assign w_cnt_nx = r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + AW'(1);
      r_rd    <= w_rd_nx;
      r_cnt   <= w_cnt_nx;
      r_valid <= (w_cnt_nx != '0);
      // New head bypasses the memory when it is the entry being written now.
      if (w_cnt_nx != '0)
        r_head <= (w_wr && (w_rd_nx == r_wr)) ? i_data : r_mem[w_rd_nx];
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_head;

endmodule

// File: rtl/svm_det_collect.sv
// Collects SVM window scores above a threshold into a detection FIFO and
// reports a per-frame summary (count, best window, overflow) on frame_done.
module svm_det_collect
  import svm_det_collect_pkg::*;
#(
  parameter int FEA_W = DET_FEA_W,
  parameter int SW_W  = DET_SW_W,
  parameter int N_SW  = 1200,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [FEA_W-1:0] thr,
  input  logic                    thr_load,
  input  logic                    i_valid,
  input  logic signed [FEA_W-1:0] i_score,
  input  logic        [SW_W-1:0]  i_sw_id,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic        [SW_W-1:0]  o_sw_id,
  output logic signed [FEA_W-1:0] o_score,
  output logic                    frame_done,
  output logic        [SW_W-1:0]  det_count,
  output logic        [SW_W-1:0]  best_sw_id,
  output logic signed [FEA_W-1:0] best_score,
  output logic                    overflow
);

  det_state_t              r_state;
  logic signed [FEA_W-1:0] r_thr;
  logic        [SW_W-1:0]  r_det_cnt;
  logic                    r_have;
  logic        [SW_W-1:0]  r_best_id;
  logic signed [FEA_W-1:0] r_best_sc;
  logic                    r_ovf;
  logic                    r_frame_done;
  logic        [SW_W-1:0]  r_det_count;
  logic        [SW_W-1:0]  r_best_sw_id;
  logic signed [FEA_W-1:0] r_best_score;
  logic                    r_overflow;

  logic                    w_qual;
  logic                    w_last;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_drop;
  det_entry_t              w_push_data;
  det_entry_t              w_head;

  logic        [SW_W-1:0]  w_base_cnt;
  logic                    w_base_have;
  logic        [SW_W-1:0]  w_base_id;
  logic signed [FEA_W-1:0] w_base_sc;
  logic                    w_base_ovf;
  logic        [SW_W-1:0]  w_cnt_nx;
  logic                    w_have_nx;
  logic        [SW_W-1:0]  w_best_id_nx;
  logic signed [FEA_W-1:0] w_best_sc_nx;
  logic                    w_ovf_nx;

  assign w_qual = i_valid && (i_score > r_thr);
  assign w_last = i_valid && (i_sw_id == SW_W'(N_SW - 1));
  assign w_pop  = o_ready && !w_empty;
  assign w_drop = w_qual && w_full && !w_pop;

  assign w_push_data.sw_id = i_sw_id;
  assign w_push_data.score = i_score;

  det_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_qual),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_valid (o_valid),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_sw_id = w_head.sw_id;
  assign o_score = w_head.score;

  // In REPORT the accumulators start from cleared values, so a window arriving
  // in that cycle lands in the new frame.
  always_comb begin
    w_base_cnt  = r_det_cnt;
    w_base_have = r_have;
    w_base_id   = r_best_id;
    w_base_sc   = r_best_sc;
    w_base_ovf  = r_ovf;
    if (r_state == ST_REPORT) begin
      w_base_cnt  = '0;
      w_base_have = 1'b0;
      w_base_id   = '0;
      w_base_sc   = SCORE_MIN;
      w_base_ovf  = 1'b0;
    end
    w_cnt_nx     = w_base_cnt;
    w_have_nx    = w_base_have;
    w_best_id_nx = w_base_id;
    w_best_sc_nx = w_base_sc;
    w_ovf_nx     = w_base_ovf || w_drop;
    if (w_qual && (w_base_cnt != {SW_W{1'b1}}))
      w_cnt_nx = w_base_cnt + SW_W'(1);
    if (w_qual && (!w_base_have || (i_score > w_base_sc))) begin
      w_have_nx    = 1'b1;
      w_best_id_nx = i_sw_id;
      w_best_sc_nx = i_score;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_SCAN;
      r_thr        <= '0;
      r_det_cnt    <= '0;
      r_have       <= 1'b0;
      r_best_id    <= '0;
      r_best_sc    <= SCORE_MIN;
      r_ovf        <= 1'b0;
      r_frame_done <= 1'b0;
      r_det_count  <= '0;
      r_best_sw_id <= '0;
      r_best_score <= SCORE_MIN;
      r_overflow   <= 1'b0;
    end else begin
      if (thr_load) r_thr <= thr;
      r_det_cnt <= w_cnt_nx;
      r_have    <= w_have_nx;
      r_best_id <= w_best_id_nx;
      r_best_sc <= w_best_sc_nx;
      r_ovf     <= w_ovf_nx;
      case (r_state)
        ST_SCAN: begin
          r_frame_done <= 1'b0;
          if (w_last) begin
            r_state      <= ST_REPORT;
            r_frame_done <= 1'b1;
            r_det_count  <= w_cnt_nx;
            r_best_sw_id <= w_best_id_nx;
            r_best_score <= w_best_sc_nx;
            r_overflow   <= w_ovf_nx;
          end
        end
        default: begin
          r_state      <= ST_SCAN;
          r_frame_done <= 1'b0;
        end
      endcase
    end
  end

  assign frame_done = r_frame_done;
  assign det_count  = r_det_count;
  assign best_sw_id = r_best_sw_id;
  assign best_score = r_best_score;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_svm_det_collect.sv
// Directed bench for svm_det_collect: per-scenario tasks with hand-computed expectations.
module tb_svm_det_collect;

  localparam int FEA_W = 12;
  localparam int SW_W  = 11;
  localparam int N_SW  = 1200;
  localparam int DEPTH = 16;
  localparam logic signed [FEA_W-1:0] SMIN = -12'sd2048;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic signed [FEA_W-1:0] thr = '0;
  logic                    thr_load = 1'b0;
  logic                    i_valid = 1'b0;
  logic signed [FEA_W-1:0] i_score = '0;
  logic        [SW_W-1:0]  i_sw_id = '0;
  logic                    o_valid;
  logic                    o_ready = 1'b0;
  logic        [SW_W-1:0]  o_sw_id;
  logic signed [FEA_W-1:0] o_score;
  logic                    frame_done;
  logic        [SW_W-1:0]  det_count;
  logic        [SW_W-1:0]  best_sw_id;
  logic signed [FEA_W-1:0] best_score;
  logic                    overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int q_id[$];
  int q_sc[$];
  logic signed [FEA_W-1:0] fscore [N_SW];
  logic                    frdy   [N_SW];

  svm_det_collect #(.FEA_W(FEA_W), .SW_W(SW_W), .N_SW(N_SW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .thr(thr), .thr_load(thr_load),
    .i_valid(i_valid), .i_score(i_score), .i_sw_id(i_sw_id),
    .o_valid(o_valid), .o_ready(o_ready), .o_sw_id(o_sw_id), .o_score(o_score),
    .frame_done(frame_done), .det_count(det_count), .best_sw_id(best_sw_id),
    .best_score(best_score), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && o_valid && o_ready) begin
      q_id.push_back(int'(o_sw_id));
      q_sc.push_back(int'(o_score));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_win(input int id, input int sc, input logic rdy);
    i_valid = 1'b1;
    i_sw_id = id[SW_W-1:0];
    i_score = sc[FEA_W-1:0];
    o_ready = rdy;
    cyc();
  endtask

  task automatic idle(input int n, input logic rdy);
    i_valid = 1'b0;
    o_ready = rdy;
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    i_valid  = 1'b0;
    o_ready  = 1'b0;
    thr_load = 1'b0;
    rst      = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    q_id.delete();
    q_sc.delete();
  endtask

  task automatic fill(input int bg, input logic rdy);
    for (int i = 0; i < N_SW; i++) begin
      fscore[i] = bg[FEA_W-1:0];
      frdy[i]   = rdy;
    end
  endtask

  task automatic play(input int lo, input int hi);
    for (int id = lo; id <= hi; id++) drive_win(id, int'(fscore[id]), frdy[id]);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) cyc();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_o_valid: got %0b expected 0", o_valid); end
    n_checks++; if (o_sw_id !== '0) begin n_fail++; $display("FAIL rst_o_sw_id: got %0d expected 0", o_sw_id); end
    n_checks++; if (o_score !== '0) begin n_fail++; $display("FAIL rst_o_score: got %0d expected 0", o_score); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %0b expected 0", frame_done); end
    n_checks++; if (det_count !== '0) begin n_fail++; $display("FAIL rst_det_count: got %0d expected 0", det_count); end
    n_checks++; if (best_sw_id !== '0) begin n_fail++; $display("FAIL rst_best_sw_id: got %0d expected 0", best_sw_id); end
    n_checks++; if (best_score !== SMIN) begin n_fail++; $display("FAIL rst_best_score: got %0d expected %0d", best_score, SMIN); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b expected 0", overflow); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_latency();
    do_reset();
    drive_win(5, 1, 1'b0);
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL lat_o_valid: got %0b expected 1", o_valid); end
    n_checks++; if (o_sw_id !== 11'd5 || o_score !== 12'sd1) begin n_fail++; $display("FAIL lat_head: got id %0d score %0d expected 5/1", o_sw_id, o_score); end
    drive_win(6, 0, 1'b0);
    idle(2, 1'b0);
    n_checks++; if (o_sw_id !== 11'd5) begin n_fail++; $display("FAIL lat_hold: got %0d expected 5", o_sw_id); end
    idle(3, 1'b1);
    n_checks++; if (q_id.size() != 1) begin n_fail++; $display("FAIL lat_eq_thr_pops: got %0d expected 1", q_id.size()); end
  endtask

  task automatic test_basic();
    int exp_id[3];
    exp_id = '{10, 20, 30};
    do_reset();
    fill(-3, 1'b1);
    fscore[10] = 12'sd5; fscore[20] = 12'sd5; fscore[30] = 12'sd5;
    play(0, N_SW-1);
    i_valid = 1'b0;
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL basic_frame_done: got %0b expected 1", frame_done); end
    n_checks++; if (det_count !== 11'd3) begin n_fail++; $display("FAIL basic_det_count: got %0d expected 3", det_count); end
    n_checks++; if (best_sw_id !== 11'd10 || best_score !== 12'sd5) begin n_fail++; $display("FAIL basic_best: got %0d/%0d expected 10/5", best_sw_id, best_score); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %0b expected 0", overflow); end
    cyc();
    n_checks++; if (frame_done !== 1'b0 || det_count !== 11'd3) begin n_fail++; $display("FAIL basic_pulse_hold: got fd %0b det %0d expected 0/3", frame_done, det_count); end
    idle(4, 1'b1);
    n_checks++; if (q_id.size() != 3) begin n_fail++; $display("FAIL basic_pop_count: got %0d expected 3", q_id.size()); end
    for (int k = 0; k < 3 && k < q_id.size(); k++) begin
      n_checks++; if (q_id[k] != exp_id[k] || q_sc[k] != 5) begin n_fail++; $display("FAIL basic_pop_order: got %0d/%0d expected %0d/5", q_id[k], q_sc[k], exp_id[k]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fill(-1, 1'b0);
    for (int k = 0; k < 20; k++) fscore[100+k] = 12'(k + 1);
    play(0, N_SW-1);
    i_valid = 1'b0;
    n_checks++; if (det_count !== 11'd20) begin n_fail++; $display("FAIL ovf_det_count: got %0d expected 20", det_count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
    n_checks++; if (best_sw_id !== 11'd119 || best_score !== 12'sd20) begin n_fail++; $display("FAIL ovf_best: got %0d/%0d expected 119/20", best_sw_id, best_score); end
    n_checks++; if (o_sw_id !== 11'd100 || o_score !== 12'sd1) begin n_fail++; $display("FAIL ovf_head_hold: got %0d/%0d expected 100/1", o_sw_id, o_score); end
    idle(1, 1'b0);
    idle(24, 1'b1);
    n_checks++; if (q_id.size() != DEPTH) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected %0d", q_id.size(), DEPTH); end
    for (int k = 0; k < DEPTH && k < q_id.size(); k++) begin
      n_checks++; if (q_id[k] != 100 + k || q_sc[k] != k + 1) begin n_fail++; $display("FAIL ovf_drain_order: got %0d/%0d expected %0d/%0d", q_id[k], q_sc[k], 100 + k, k + 1); end
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    fill(-1, 1'b0);
    for (int k = 0; k <= 16; k++) fscore[k] = 12'sd7;
    frdy[16] = 1'b1;
    play(0, N_SW-1);
    i_valid = 1'b0;
    n_checks++; if (det_count !== 11'd17) begin n_fail++; $display("FAIL fpp_det_count: got %0d expected 17", det_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow: got %0b expected 0", overflow); end
    n_checks++; if (o_sw_id !== 11'd1) begin n_fail++; $display("FAIL fpp_head: got %0d expected 1", o_sw_id); end
    idle(1, 1'b0);
    idle(24, 1'b1);
    n_checks++; if (q_id.size() != 17) begin n_fail++; $display("FAIL fpp_drain_count: got %0d expected 17", q_id.size()); end
    for (int k = 0; k < 17 && k < q_id.size(); k++) begin
      n_checks++; if (q_id[k] != k) begin n_fail++; $display("FAIL fpp_drain_order: got %0d expected %0d", q_id[k], k); end
    end
  endtask

  task automatic test_threshold();
    do_reset();
    thr = 12'sd4; thr_load = 1'b1;
    cyc();
    thr_load = 1'b0;
    fill(4, 1'b1);
    play(0, N_SW-1);
    i_valid = 1'b0;
    n_checks++; if (det_count !== 11'd0) begin n_fail++; $display("FAIL thr_eq_det: got %0d expected 0", det_count); end
    n_checks++; if (best_sw_id !== 11'd0 || best_score !== SMIN) begin n_fail++; $display("FAIL thr_eq_best: got %0d/%0d expected 0/%0d", best_sw_id, best_score, SMIN); end
    n_checks++; if (q_id.size() != 0) begin n_fail++; $display("FAIL thr_eq_pops: got %0d expected 0", q_id.size()); end
    cyc();
    fscore[7] = 12'sd5;
    play(0, N_SW-1);
    i_valid = 1'b0;
    n_checks++; if (det_count !== 11'd1 || best_sw_id !== 11'd7 || best_score !== 12'sd5) begin n_fail++; $display("FAIL thr_gt: got %0d %0d/%0d expected 1 7/5", det_count, best_sw_id, best_score); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_win(0, 9, 1'b0);
    drive_win(1, 9, 1'b0);
    drive_win(2, 9, 1'b0);
    drive_win(3, -1, 1'b0);
    i_valid = 1'b0;
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pending: got %0b expected 1", o_valid); end
    rst = 1'b0;
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_o_valid: got %0b expected 0", o_valid); end
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    q_id.delete(); q_sc.delete();
    fill(-1, 1'b1);
    fscore[50] = 12'sd2;
    play(0, N_SW-1);
    i_valid = 1'b0;
    n_checks++; if (det_count !== 11'd1 || best_sw_id !== 11'd50 || best_score !== 12'sd2) begin n_fail++; $display("FAIL rmid_frame: got %0d %0d/%0d expected 1 50/2", det_count, best_sw_id, best_score); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_overflow: got %0b expected 0", overflow); end
    idle(4, 1'b1);
    n_checks++; if (q_id.size() != 1 || (q_id.size() == 1 && q_id[0] != 50)) begin n_fail++; $display("FAIL rmid_pops: got %0d entries expected 1 (id 50)", q_id.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill(-1, 1'b1);
    fscore[600] = 12'sd8;
    play(0, N_SW-1);
    n_checks++; if (det_count !== 11'd1 || best_sw_id !== 11'd600) begin n_fail++; $display("FAIL b2b_first: got %0d %0d expected 1 600", det_count, best_sw_id); end
    drive_win(0, 3, 1'b1);
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse: got %0b expected 0", frame_done); end
    fill(-1, 1'b1);
    play(1, N_SW-1);
    i_valid = 1'b0;
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_frame_done: got %0b expected 1", frame_done); end
    n_checks++; if (det_count !== 11'd1 || best_sw_id !== 11'd0 || best_score !== 12'sd3) begin n_fail++; $display("FAIL b2b_second: got %0d %0d/%0d expected 1 0/3", det_count, best_sw_id, best_score); end
    idle(3, 1'b1);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_threshold();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
